// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//   Groups the request/response handshake from the pipeline and the start-
//   pulsed word-memory bus of the load/store controller into one bundle.
//
//   slave  : the controller's view (consumes requests and memory replies,
//            drives responses and memory commands).
//   master : the environment's view (pipeline issuing requests plus the data
//            memory answering accesses).
//
//   Signals
//     req_valid/req_ready       request handshake, accept = valid & ready
//     req_write/req_size/req_signed/req_address/req_wdata  request fields
//     resp_valid/resp_rdata/resp_error                     completion pulse
//     mem_start/mem_write_enabled/mem_address/mem_input_data  memory command
//     mem_valid/mem_output_data/mem_err_invalid_address       memory reply
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [WORD_SIZE-1:0] req_address;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 resp_valid;
    logic [WORD_SIZE-1:0] resp_rdata;
    logic [1:0]           resp_error;
    logic                 mem_start;
    logic                 mem_write_enabled;
    logic [WORD_SIZE-1:0] mem_address;
    logic [WORD_SIZE-1:0] mem_input_data;
    logic                 mem_valid;
    logic [WORD_SIZE-1:0] mem_output_data;
    logic                 mem_err_invalid_address;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_address, req_wdata,
        input  mem_valid, mem_output_data, mem_err_invalid_address,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_start, mem_write_enabled, mem_address, mem_input_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_address, req_wdata,
        output mem_valid, mem_output_data, mem_err_invalid_address,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_start, mem_write_enabled, mem_address, mem_input_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Load/store stage in front of a word-addressed data memory. Converts byte-
//   addressed lw/lh/lb/sw/sh/sb requests into start-pulsed word accesses:
//   alignment check, lane extraction with sign/zero extension, read-modify-
//   write for sub-word stores, address-error capture and a wait timeout.
//   One request in flight; every accepted request ends in one resp_valid
//   pulse (unless reset intervenes).
//
//   Ports
//     clock  : rising-edge clock
//     reset  : synchronous, active-high
//     bus    : mem_access_ctrl_if.slave (request, response and memory bus)
//
//   resp_error: 00 ok, 01 misaligned, 10 invalid address, 11 timeout.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ADDRESS  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT     = 3'd3,
        ST_WR_SETUP = 3'd4,
        ST_WR_START = 3'd5,
        ST_RESP     = 3'd6
    } state_t;

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [WORD_SIZE-1:0] extract_lane(
        input logic [WORD_SIZE-1:0] word,
        input logic [1:0]           size,
        input logic [1:0]           lane,
        input logic                 sgn
    );
        logic [7:0]           byte_s;
        logic [15:0]          half_s;
        logic [WORD_SIZE-1:0] res_s;
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (size)
            SIZE_BYTE: res_s = {{24{sgn & byte_s[7]}}, byte_s};
            SIZE_HALF: res_s = {{16{sgn & half_s[15]}}, half_s};
            default:   res_s = word;
        endcase
        return res_s;
    endfunction

    // Overlay the low byte/half of the store data onto one lane of a word.
    function automatic logic [WORD_SIZE-1:0] merge_lane(
        input logic [WORD_SIZE-1:0] word,
        input logic [WORD_SIZE-1:0] wdata,
        input logic [1:0]           size,
        input logic [1:0]           lane
    );
        logic [WORD_SIZE-1:0] res_s;
        res_s = word;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    res_s[7:0]   = wdata[7:0];
                    2'd1:    res_s[15:8]  = wdata[7:0];
                    2'd2:    res_s[23:16] = wdata[7:0];
                    2'd3:    res_s[31:24] = wdata[7:0];
                    default: res_s        = word;
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) begin
                    res_s[31:16] = wdata[15:0];
                end else begin
                    res_s[15:0]  = wdata[15:0];
                end
            end
            default:   res_s = wdata;
        endcase
        return res_s;
    endfunction

    state_t               state_r;
    logic                 write_r;
    logic [1:0]           size_r;
    logic                 signed_r;
    logic [1:0]           lane_r;
    logic [WORD_SIZE-1:0] wdata_r;
    logic [CNT_W-1:0]     tmo_cnt_r;

    logic                 req_ready_r;
    logic                 resp_valid_r;
    logic [WORD_SIZE-1:0] resp_rdata_r;
    logic [1:0]           resp_error_r;
    logic                 mem_start_r;
    logic                 mem_we_r;
    logic [WORD_SIZE-1:0] mem_addr_r;
    logic [WORD_SIZE-1:0] mem_wdata_r;

    logic                 misalign_s;
    logic                 word_store_s;

    // Alignment of the request currently offered on the bus.
    always_comb begin
        misalign_s = 1'b0;
        case (bus.req_size)
            SIZE_BYTE: misalign_s = 1'b0;
            SIZE_HALF: misalign_s = bus.req_address[0];
            SIZE_WORD: misalign_s = (bus.req_address[1:0] != 2'b00);
            default:   misalign_s = 1'b1;
        endcase
    end

    // Full-word stores go straight to memory; sub-word stores need a read first.
    assign word_store_s = bus.req_write & (bus.req_size == SIZE_WORD);

    // Transaction sequencer; all bus outputs are registered here so the memory
    // command fields settle a full cycle before each mem_start pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            signed_r     <= 1'b0;
            lane_r       <= 2'b00;
            wdata_r      <= '0;
            tmo_cnt_r    <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_error_r <= ERR_OK;
            mem_start_r  <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        write_r     <= bus.req_write;
                        size_r      <= bus.req_size;
                        signed_r    <= bus.req_signed;
                        lane_r      <= bus.req_address[1:0];
                        wdata_r     <= bus.req_wdata;
                        req_ready_r <= 1'b0;
                        mem_addr_r  <= {2'b00, bus.req_address[WORD_SIZE-1:2]};
                        if (misalign_s) begin
                            // Rejected before any memory traffic.
                            mem_we_r     <= 1'b0;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= '0;
                            resp_error_r <= ERR_MISALIGN;
                            state_r      <= ST_RESP;
                        end else begin
                            mem_we_r <= word_store_s;
                            if (word_store_s) begin
                                mem_wdata_r <= bus.req_wdata;
                            end else begin
                                mem_wdata_r <= mem_wdata_r;
                            end
                            state_r <= ST_SETUP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    // Memory flags the range error combinationally from mem_address.
                    if (bus.mem_err_invalid_address) begin
                        mem_we_r     <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= '0;
                        resp_error_r <= ERR_ADDRESS;
                        state_r      <= ST_RESP;
                    end else begin
                        mem_start_r <= 1'b1;
                        state_r     <= ST_START;
                    end
                end
                ST_START: begin
                    mem_start_r <= 1'b0;
                    if (write_r && (size_r == SIZE_WORD)) begin
                        mem_we_r     <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= '0;
                        resp_error_r <= ERR_OK;
                        state_r      <= ST_RESP;
                    end else begin
                        tmo_cnt_r <= '0;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_valid) begin
                        if (write_r) begin
                            // Prepare the merged word now so it is stable through WR_SETUP.
                            mem_wdata_r <= merge_lane(bus.mem_output_data, wdata_r, size_r, lane_r);
                            mem_we_r    <= 1'b1;
                            state_r     <= ST_WR_SETUP;
                        end else begin
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= extract_lane(bus.mem_output_data, size_r, lane_r, signed_r);
                            resp_error_r <= ERR_OK;
                            state_r      <= ST_RESP;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            mem_we_r     <= 1'b0;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= '0;
                            resp_error_r <= ERR_TIMEOUT;
                            state_r      <= ST_RESP;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WR_SETUP: begin
                    mem_start_r <= 1'b1;
                    state_r     <= ST_WR_START;
                end
                ST_WR_START: begin
                    mem_start_r  <= 1'b0;
                    mem_we_r     <= 1'b0;
                    resp_valid_r <= 1'b1;
                    resp_rdata_r <= '0;
                    resp_error_r <= ERR_OK;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= '0;
                    resp_error_r <= ERR_OK;
                    mem_start_r  <= 1'b0;
                    mem_we_r     <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    mem_start_r  <= 1'b0;
                    mem_we_r     <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready         = req_ready_r;
    assign bus.resp_valid        = resp_valid_r;
    assign bus.resp_rdata        = resp_rdata_r;
    assign bus.resp_error        = resp_error_r;
    assign bus.mem_start         = mem_start_r;
    assign bus.mem_write_enabled = mem_we_r;
    assign bus.mem_address       = mem_addr_r;
    assign bus.mem_input_data    = mem_wdata_r;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store stage sitting directly upstream of the word-addressed data memory block; converts pipeline byte-addressed lw/lh/lb/sw/sh/sb requests into start-pulsed memory transactions.
- Handles alignment checks, sub-word extraction with sign/zero extension, read-modify-write for sub-word stores, memory address-error capture and a wait timeout.
- One request in flight; valid/ready request side, one-cycle response pulse.

Parameters:
- WORD_SIZE, 32, data/address width; only 32 supported (4 byte lanes).
- TIMEOUT_CYCLES, 15, max WAIT cycles for mem_valid before timeout error.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as misaligned.
- req_signed  in  1  loads: sign-extend sub-word (else zero-extend).
- req_address  in  WORD_SIZE  byte address; word index = req_address >> 2, lane = req_address[1:0], little-endian.
- req_wdata  in  WORD_SIZE  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WORD_SIZE  load result, valid with resp_valid; 0 for stores and errors.
- resp_error  out  2  00 ok, 01 misaligned, 10 invalid address, 11 timeout.
- mem_start  out  1  to memory start; rising edge launches an access.
- mem_write_enabled  out  1  to memory write_enabled.
- mem_address  out  WORD_SIZE  word index to memory.
- mem_input_data  out  WORD_SIZE  write word to memory.
- mem_valid  in  1  memory read-data valid.
- mem_output_data  in  WORD_SIZE  memory read word.
- mem_err_invalid_address  in  1  memory address-range error.

Behaviour:
- Reset: state IDLE; req_ready 1; resp_valid 0; resp_rdata 0; resp_error 00; mem_start 0; mem_write_enabled 0; mem_address 0; mem_input_data 0; timeout counter 0.
- States: IDLE, SETUP, START, WAIT, WR_SETUP, WR_START, RESP.
- IDLE: on accept, latch all req fields; mem_address <= req_address>>2; mem_write_enabled <= (word store); mem_input_data <= req_wdata for word store. Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size 11) -> RESP err 01, no memory access; else -> SETUP.
- SETUP (mem_start 0): if mem_err_invalid_address -> RESP err 10; else -> START.
- START: mem_start 1 for exactly one cycle. Word store -> RESP ok. Load or sub-word store -> WAIT, counter cleared.
- WAIT (mem_start 0): mem_valid high -> latch mem_output_data; load -> RESP with extracted lane; sub-word store -> merge req_wdata low byte/half into the selected lane, other lanes unchanged -> WR_SETUP. Else counter++; counter reaching TIMEOUT_CYCLES -> RESP err 11.
- WR_SETUP (mem_start 0): mem_write_enabled 1, mem_input_data = merged word -> WR_START.
- WR_START: mem_start 1 one cycle -> RESP ok.
- RESP: resp_valid 1 one cycle; mem_start 0; mem_write_enabled 0 -> IDLE.
- Stability rule: mem_address, mem_write_enabled, mem_input_data change only while mem_start is 0, and are stable at least one full cycle before mem_start rises and throughout its high cycle.
- Latency from accept cycle N: word load resp_valid at N+4; word store N+3; sub-word store N+6; misaligned N+1; invalid address N+2; timeout N+3+TIMEOUT_CYCLES.
- mem_start is never high in two consecutive cycles; at least one low cycle separates any two rising edges.
- Extraction: byte lane k = bits [8k+7:8k]; half lane uses addr[1] (bits [15:0] or [31:16]).
- Reset mid-operation: immediately to IDLE with reset values. A write whose mem_start edge already occurred stands; no response is emitted.
- req_valid while not IDLE: ignored (req_ready 0); request fields are not sampled.

Test Plan:
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> store resp at N+3 err 00; load resp at N+4, rdata 0xDEADBEEF, err 00, mem_address 4.
- Signed lb at 0x13 over word 0x80FF7F01 -> rdata 0xFFFFFF80; unsigned lbu -> 0x00000080; lh signed at 0x12 -> 0xFFFF80FF.
- sb 0xAA at 0x11 over word 0x11223344 -> exactly two mem_start pulses; memory word 0x1122AA44; resp at N+6 err 00.
- lw at 0x06 and lh at 0x01 -> resp at N+1, err 01, mem_start never rises.
- Address 0x00001000 (index 1024 ≥ MEMORY_SIZE) -> resp at N+2, err 10, no mem_start; load with mem_valid held 0 -> resp at N+18, err 11.
- Reset asserted during WAIT -> next cycle IDLE, req_ready 1, mem_start 0, no resp_valid; back-to-back requests show req_ready low throughout each transaction.
